// File: rtl/sec_to_mmss_pkg.sv
// Shared definitions for the seconds-to-mm:ss converter.
// Contents: FSM state encoding, the default seconds-per-minute divisor,
// the BCD radix and the width of one BCD digit.
package sec_to_mmss_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SPLIT,
    DONE
  } state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int BCD_BASE    = 10;
  localparam int DIGIT_W     = 4;

endpackage

// File: rtl/sec_to_mmss_if.sv
// Bundle between the seconds timer / display side and the converter.
// Signals:
//   in        binary seconds count (timer -> converter)
//   min_tens  BCD tens of minutes
//   min_ones  BCD ones of minutes
//   sec_tens  BCD tens of seconds
//   sec_ones  BCD ones of seconds
//   busy      conversion in progress
//   update    one-cycle pulse when the digits take a new value
// Modports: master = timer/display side, slave = converter.
interface sec_to_mmss_if #(
  parameter int WIDTH = 10
);
  import sec_to_mmss_pkg::*;

  logic [WIDTH-1:0]   in;
  logic [DIGIT_W-1:0] min_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               busy;
  logic               update;

  modport master (
    output in,
    input  min_tens, min_ones, sec_tens, sec_ones, busy, update
  );

  modport slave (
    input  in,
    output min_tens, min_ones, sec_tens, sec_ones, busy, update
  );

endinterface

// File: rtl/sec_to_mmss_bcd_split_step.sv
// One combinational step of binary-to-BCD splitting: if val >= 10,
// subtract 10 and flag that the tens digit should be bumped.
// Ports:
//   val       current remainder
//   val_next  remainder after this step (unchanged when val < 10)
//   bump      high when a ten was taken off
module sec_to_mmss_bcd_split_step #(
  parameter int W = 7
) (
  input  logic [W-1:0] val,
  output logic [W-1:0] val_next,
  output logic         bump
);
  import sec_to_mmss_pkg::*;

  // Compare in a width that can always hold the constant 10, so narrow
  // instances never see a truncated radix.
  localparam int CMP_W = (W > DIGIT_W) ? W : DIGIT_W;

  assign bump     = (CMP_W'(val) >= CMP_W'(BCD_BASE));
  assign val_next = bump ? (val - W'(BCD_BASE)) : val;

endmodule

// File: rtl/sec_to_mmss.sv
// Converts a binary seconds count into four BCD digits mm:ss by
// iterative subtraction (no dividers). A new conversion starts whenever
// the input differs from the last captured value while idle; the digit
// outputs change together, once per completed conversion, with a
// one-cycle update pulse.
// Ports:
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset
//   bus  sec_to_mmss_if.slave: in, min_tens, min_ones, sec_tens,
//        sec_ones, busy, update
module sec_to_mmss #(
  parameter int WIDTH       = 10,
  parameter int SEC_PER_MIN = 60
) (
  input  logic               clk,
  input  logic               rst,
  sec_to_mmss_if.slave       bus
);
  import sec_to_mmss_pkg::*;

  localparam int MINS_W = 7;
  // Wide enough to hold both rem and the divisor without truncation.
  localparam int CMP_W  = (WIDTH > MINS_W) ? WIDTH : MINS_W;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cap_q;
  logic [WIDTH-1:0]   rem_q;
  logic [MINS_W-1:0]  mins_q;
  logic [DIGIT_W-1:0] mt_q;
  logic [DIGIT_W-1:0] st_q;
  logic [DIGIT_W-1:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic               busy_q;
  logic               update_q;

  logic               rem_ge_min;
  logic [MINS_W-1:0]  mins_step;
  logic [WIDTH-1:0]   rem_step;
  logic               bump_min;
  logic               bump_sec;

  assign rem_ge_min = (CMP_W'(rem_q) >= CMP_W'(SEC_PER_MIN));

  sec_to_mmss_bcd_split_step #(.W(MINS_W)) u_split_min (
    .val      (mins_q),
    .val_next (mins_step),
    .bump     (bump_min)
  );

  sec_to_mmss_bcd_split_step #(.W(WIDTH)) u_split_sec (
    .val      (rem_q),
    .val_next (rem_step),
    .bump     (bump_sec)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in != cap_q) state_d = DIV;
      DIV:     if (!rem_ge_min) state_d = SPLIT;
      SPLIT:   if (!bump_min && !bump_sec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      rem_q      <= '0;
      mins_q     <= '0;
      mt_q       <= '0;
      st_q       <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      update_q <= 1'b0;
      case (state_q)
        // Input is only looked at here, so changes during a conversion
        // are picked up on the next pass through IDLE.
        IDLE: begin
          if (bus.in != cap_q) begin
            cap_q  <= bus.in;
            rem_q  <= bus.in;
            mins_q <= '0;
            mt_q   <= '0;
            st_q   <= '0;
            busy_q <= 1'b1;
          end
        end
        DIV: begin
          if (rem_ge_min) begin
            rem_q  <= rem_q - WIDTH'(SEC_PER_MIN);
            mins_q <= mins_q + MINS_W'(1);
          end
        end
        // Minutes and seconds split into tens/ones concurrently.
        SPLIT: begin
          if (bump_min) begin
            mins_q <= mins_step;
            mt_q   <= mt_q + DIGIT_W'(1);
          end
          if (bump_sec) begin
            rem_q <= rem_step;
            st_q  <= st_q + DIGIT_W'(1);
          end
        end
        // All four digits land on the same edge.
        DONE: begin
          min_tens_q <= mt_q;
          min_ones_q <= DIGIT_W'(mins_q);
          sec_tens_q <= st_q;
          sec_ones_q <= DIGIT_W'(rem_q);
          update_q   <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.min_tens = min_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.sec_ones = sec_ones_q;
  assign bus.busy     = busy_q;
  assign bus.update   = update_q;

endmodule

// File: tb/tb_sec_to_mmss.sv
// Scoreboard bench for sec_to_mmss: stimulus pushes the expected mm:ss
// digits and latency for each value; a negedge monitor pops and checks
// on every update pulse, and also checks that digits only move on update.
module tb_sec_to_mmss;

  localparam int WIDTH = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sec_to_mmss_if #(.WIDTH(WIDTH)) bus ();

  sec_to_mmss #(.WIDTH(WIDTH), .SEC_PER_MIN(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int v;
    int digits;
    int lat;
    int sample_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        rst_at_edge;
  bit          sb_en = 1'b0;
  bit          chk_en = 1'b0;
  logic [15:0] prev_digits;
  logic [15:0] mon_d;
  exp_t        mon_e;
  int          mon_v;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic logic [15:0] cur_digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain division of the seconds count, then the latency rule.
  function automatic exp_t model(input int v);
    exp_t e;
    int q, r, tm, ts;
    q  = v / 60;
    r  = v % 60;
    tm = q / 10;
    ts = r / 10;
    e.v           = v;
    e.digits      = (tm << 12) | ((q % 10) << 8) | (ts << 4) | (r % 10);
    e.lat         = 1 + (q + 1) + (((tm > ts) ? tm : ts) + 1) + 1;
    e.sample_edge = 0;
    return e;
  endfunction

  // Monitor: digit stability plus scoreboard pops on update.
  always @(negedge clk) begin
    if (chk_en) begin
      mon_d = cur_digits();
      if (rst_at_edge === 1'b0 && bus.update !== 1'b1)
        check("digits_hold", 32'(mon_d), 32'(prev_digits));
      prev_digits = mon_d;
      if (bus.update === 1'b1) begin
        check("busy_at_update", 32'(bus.busy), 32'd0);
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_update: got digits 0x%0h, expected no update", mon_d);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("digits_v%0d", mon_e.v), 32'(mon_d), mon_e.digits);
            check($sformatf("latency_v%0d", mon_e.v), cyc - mon_e.sample_edge + 1, mon_e.lat);
          end
        end else begin
          mon_v = (int'(mon_d[15:12]) * 10 + int'(mon_d[11:8])) * 60
                + int'(mon_d[7:4]) * 10 + int'(mon_d[3:0]);
          check("ramp_value_in_range", 32'(mon_v >= 127 && mon_v <= 137), 32'd1);
        end
      end
    end
  end

  // Drive a new value (called at a negedge with the DUT idle) and wait
  // for its update, checking busy stays high meanwhile.
  task automatic apply(input int v);
    exp_t e;
    e = model(v);
    bus.in = WIDTH'(v);
    e.sample_edge = cyc + 1;
    exp_q.push_back(e);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.update === 1'b1) return;
      check($sformatf("busy_during_v%0d", v), 32'(bus.busy), 32'd1);
    end
    n_vec++;
    n_bad++;
    $display("FAIL timeout_v%0d: got no update in 60 cycles, expected one", v);
    exp_q.delete();
  endtask

  initial begin
    int idle_act;
    int cur;
    int v;

    rst    = 1'b1;
    bus.in = '0;
    repeat (3) @(negedge clk);
    check("rst_min_tens", 32'(bus.min_tens), 32'd0);
    check("rst_min_ones", 32'(bus.min_ones), 32'd0);
    check("rst_sec_tens", 32'(bus.sec_tens), 32'd0);
    check("rst_sec_ones", 32'(bus.sec_ones), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_update",   32'(bus.update),   32'd0);
    rst         = 1'b0;
    prev_digits = cur_digits();
    chk_en      = 1'b1;
    sb_en       = 1'b1;

    // Input equal to the reset capture: nothing should happen.
    idle_act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.update !== 1'b0) idle_act++;
    end
    check("idle_activity", idle_act, 0);
    check("idle_digits", 32'(cur_digits()), 32'h0);

    apply(59);
    apply(60);
    apply(1023);
    apply(1019);

    // Ramp while converting; intermediate values may be skipped.
    apply(127);
    @(negedge clk);
    sb_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.in = WIDTH'(127 + i);
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    check("ramp_final_digits", 32'(cur_digits()), 32'h0217);
    check("ramp_final_busy", 32'(bus.busy), 32'd0);
    sb_en = 1'b1;

    // Reset in the middle of the DIV phase.
    bus.in = WIDTH'(900);
    repeat (3) @(negedge clk);
    check("div_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_digits", 32'(cur_digits()), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_update", 32'(bus.update), 32'd0);
    rst = 1'b0;
    apply(900);
    cur = 900;

    // Full sweep of the input range.
    for (int s = 0; s < 1024; s++) begin
      if (s != cur) begin
        apply(s);
        cur = s;
      end
    end

    // Random jumps.
    repeat (300) begin
      v = int'($urandom_range(0, 1023));
      if (v != cur) begin
        apply(v);
        cur = v;
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
